// File: rtl/fixedpoint_mul_arb.sv
// fixedpoint_mul_arb: round-robin time-sharing of one Q4.4 x Q4.4 -> Q7.1 signed multiplier among NREQ requesters
module fixedpoint_mul_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_in1,
   input  logic [8*NREQ-1:0] req_in2,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_out,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] last_q, id_q, gnt_id;
   logic gnt_vld;
   logic [7:0] op1_q, op2_q, rsp_out_q;
   logic rsp_valid_q;
   logic [15:0] prod;
   int cand;
   // first valid requester after the last grant, wrapping modulo NREQ
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id = last_q;
      cand = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id = cand[IDW-1:0];
         end
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (gnt_vld ? MUL : IDLE) :
                (state_q == MUL)  ? RESP : (rsp_ready ? IDLE : RESP);
   end
   always_comb begin
      req_ready = (state_q == IDLE && gnt_vld) ? NREQ'(1) << gnt_id : '0;
      busy = state_q != IDLE;
      rsp_valid = rsp_valid_q;
      rsp_out = rsp_out_q;
      rsp_id = id_q;
   end
   assign prod = 16'($signed(op1_q)) * 16'($signed(op2_q));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q <= IDW'(NREQ - 1);
         id_q <= '0;
         op1_q <= '0;
         op2_q <= '0;
         rsp_out_q <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && gnt_vld) begin
            last_q <= gnt_id;
            id_q <= gnt_id;
            op1_q <= req_in1[8*gnt_id +: 8];
            op2_q <= req_in2[8*gnt_id +: 8];
         end
         if (state_q == MUL) begin
            rsp_out_q <= prod[14:7];
            rsp_valid_q <= 1'b1;
         end
         if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fixedpoint_mul_arb.sv
// tb_fixedpoint_mul_arb: directed self-checking bench for the shared fixed-point multiplier arbiter
module tb_fixedpoint_mul_arb;
   logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
   logic [3:0] req_valid = '0;
   logic [31:0] req_in1 = '0, req_in2 = '0;
   logic [3:0] req_ready;
   logic rsp_valid, busy;
   logic [1:0] rsp_id;
   logic [7:0] rsp_out;
   int n_cmp = 0, n_err = 0;

   fixedpoint_mul_arb #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] b);
      req_in1[8*i +: 8] = a;
      req_in2[8*i +: 8] = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_cmp++; if (rsp_out !== 8'h00) begin n_err++; $display("FAIL reset_rsp_out got %h exp 00", rsp_out); end
      n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_slot(0, 8'hF0, 8'hF0);
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_mul got ready=%b busy=%b vld=%b exp 0000/1/0", req_ready, busy, rsp_valid); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h02 || rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp got vld=%b out=%h id=%0d exp 1/02/0", rsp_valid, rsp_out, rsp_id); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got vld=%b busy=%b exp 0/0", rsp_valid, busy); end
   endtask

   task automatic test_sign();
      logic [7:0] a [3] = '{8'hE8, 8'hEC, 8'h80};
      logic [7:0] b [3] = '{8'h30, 8'h30, 8'h80};
      logic [7:0] e [3] = '{8'hF7, 8'hF8, 8'h80};
      rsp_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         set_slot(2, a[v], b[v]);
         req_valid = 4'b0100;
         #1;
         n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sign_grant%0d got %b exp 0100", v, req_ready); end
         tick();
         req_valid = '0;
         tick();
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_out !== e[v] || rsp_id !== 2'd2) begin n_err++; $display("FAIL sign_rsp%0d got vld=%b out=%h id=%0d exp 1/%h/2", v, rsp_valid, rsp_out, rsp_id, e[v]); end
         tick();
      end
   endtask

   task automatic test_fairness();
      logic [1:0] eid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] eout [5] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h02};
      do_reset();
      set_slot(0, 8'h10, 8'h10);
      set_slot(1, 8'h20, 8'h10);
      set_slot(2, 8'h30, 8'h10);
      set_slot(3, 8'h40, 8'h10);
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         #1;
         n_cmp++; if (req_ready !== (4'b0001 << eid[t])) begin n_err++; $display("FAIL fair_grant%0d got %b exp id %0d", t, req_ready, eid[t]); end
         tick();
         n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL fair_mul_ready%0d got %b exp 0000", t, req_ready); end
         tick();
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== eid[t] || rsp_out !== eout[t]) begin n_err++; $display("FAIL fair_rsp%0d got vld=%b id=%0d out=%h exp 1/%0d/%h", t, rsp_valid, rsp_id, rsp_out, eid[t], eout[t]); end
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
      tick();
      req_valid = 4'b0100;
      tick();
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h04 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d got vld=%b out=%h id=%0d ready=%b busy=%b exp 1/04/1/0000/1", c, rsp_valid, rsp_out, rsp_id, req_ready, busy); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release got vld=%b ready=%b exp 0/0100", rsp_valid, req_ready); end
      tick();
      req_valid = '0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_next_busy got %b exp 1", busy); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h06 || rsp_id !== 2'd2) begin n_err++; $display("FAIL bp_next_rsp got vld=%b out=%h id=%0d exp 1/06/2", rsp_valid, rsp_out, rsp_id); end
      tick();
   endtask

   task automatic test_async_reset();
      set_slot(0, 8'hF0, 8'hF0);
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      tick();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_in_mul got busy=%b exp 1", busy); end
      #2;
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL ar_immediate got vld=%b busy=%b ready=%b exp 0/0/0000", rsp_valid, busy, req_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ar_no_rsp%0d got vld=%b busy=%b exp 0/0", c, rsp_valid, busy); end
         tick();
      end
      req_valid = 4'b1010;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ar_first_grant got %b exp 0010", req_ready); end
      tick();
      req_valid = '0;
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 8'h04) begin n_err++; $display("FAIL ar_rsp got vld=%b id=%0d out=%h exp 1/1/04", rsp_valid, rsp_id, rsp_out); end
      tick();
   endtask

   task automatic test_withdrawal();
      set_slot(0, 8'hF0, 8'hF0);
      set_slot(3, 8'h40, 8'h10);
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_grant got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      tick();
      req_valid = 4'b1000;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wd_resp_ready got %b exp 0000", req_ready); end
      tick();
      req_valid = '0;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h02 || rsp_id !== 2'd0) begin n_err++; $display("FAIL wd_rsp got vld=%b out=%h id=%0d exp 1/02/0", rsp_valid, rsp_out, rsp_id); end
      rsp_ready = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL wd_idle%0d got vld=%b busy=%b ready=%b exp 0/0/0000", c, rsp_valid, busy, req_ready); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sign();
      test_fairness();
      test_back_to_back();
      test_async_reset();
      test_withdrawal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
